// File: rtl/sevenseg4_scan_pkg.sv
// Shared constants and small helpers for the 4-digit multiplexed seven-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package sevenseg4_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_ALL_OFF       = 4'hF;
  localparam logic [3:0] SHADOW_DIGIT_RST = 4'hF;
  localparam logic [3:0] SHADOW_DP_RST    = 4'h0;

  typedef logic [1:0] digit_idx_t;

  function automatic logic is_bcd(input logic [3:0] v);
    return (v <= 4'd9);
  endfunction

  function automatic logic [3:0] anode_onecold(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sevenseg4_scan_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes blank the digit.
module bcd_to_7seg
  import sevenseg4_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pattern lookup
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg4_scan.sv
// Time-multiplexed driver for a 4-digit common-anode display with shadowed BCD inputs.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros on digits 3..1).
module sevenseg4_scan
  import sevenseg4_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic       update,
  input  logic [3:0] dp_in,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [15:0] TC_VAL = 16'(SCAN_DIV - 1);

  logic [15:0]      presc_q, presc_d;
  logic             tc_s;
  digit_idx_t       idx_q, idx_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       cur_digit_s;
  logic [6:0]       dec_seg_s;
  logic             lz_blank_s;
  logic             digit_blank_s;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  assign tc_s        = (presc_q == TC_VAL);
  assign cur_digit_s = shadow_q[idx_q];

  bcd_to_7seg u_dec (
    .bcd_i (cur_digit_s),
    .seg_o (dec_seg_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant digit are zero
  always_comb begin
    lz_blank_s = 1'b0;
    case (idx_q)
      2'd3:    lz_blank_s = (shadow_q[3] == 4'd0);
      2'd2:    lz_blank_s = (shadow_q[3] == 4'd0) && (shadow_q[2] == 4'd0);
      2'd1:    lz_blank_s = (shadow_q[3] == 4'd0) && (shadow_q[2] == 4'd0) &&
                            (shadow_q[1] == 4'd0);
      default: lz_blank_s = 1'b0;
    endcase
  end
`else
  assign lz_blank_s = 1'b0;
`endif

  assign digit_blank_s = !is_bcd(cur_digit_s) || lz_blank_s;

  // Next-state for prescaler, index and shadow registers
  always_comb begin
    presc_d     = presc_q + 16'd1;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (tc_s) begin
      presc_d = 16'd0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      idx_d   = idx_q;
    end
    if (update) begin
      shadow_d    = {D, C, B, A};
      shadow_dp_d = dp_in;
    end else begin
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
    end
  end

  // Output values computed from the current index/shadow; registered one cycle later
  always_comb begin
    an_d  = AN_ALL_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (blank) begin
      an_d = AN_ALL_OFF;
    end else begin
      an_d = anode_onecold(idx_q);
    end
    if (digit_blank_s) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else begin
      seg_d = dec_seg_s;
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= 16'd0;
      idx_q       <= 2'd0;
      shadow_q    <= {4{SHADOW_DIGIT_RST}};
      shadow_dp_q <= SHADOW_DP_RST;
      an_q        <= AN_ALL_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_sevenseg4_scan.sv
// Directed self-checking bench for sevenseg4_scan with SCAN_DIV=4.
// Honours LEADING_ZERO_BLANK_EN when the same macro is set for the build.
module tb_sevenseg4_scan;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] A = 4'd0, B = 4'd0, C = 4'd0, D = 4'd0;
  logic       update = 1'b0;
  logic [3:0] dp_in = 4'd0;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  logic [3:0] sh [4];
  logic [3:0] sh_dp;

  always #5 clk = ~clk;

  sevenseg4_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .update (update),
    .dp_in  (dp_in),
    .blank  (blank),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic lz_ref(input int i);
    logic r;
    r = (i != 0);
    for (int j = i; j < 4; j++) begin
      if (sh[j] != 4'd0) r = 1'b0;
    end
`ifndef LEADING_ZERO_BLANK_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Displayed digit after k edges since reset release: 4 edges per digit, first edge shows digit 0
  task automatic check_cur(input string tag);
    int idx;
    logic bl;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    idx = ((k - 1) / 4) % 4;
    bl  = (sh[idx] > 4'd9) || lz_ref(idx);
    ea  = blank ? 4'hF : ~(4'b0001 << idx);
    es  = bl ? 7'h7F : seg_ref(sh[idx]);
    ed  = bl ? 1'b1 : ~sh_dp[idx];
    check_eq($sformatf("%s_an_k%0d", tag, k), an, ea);
    check_eq($sformatf("%s_seg_k%0d", tag, k), seg, es);
    check_eq($sformatf("%s_dp_k%0d", tag, k), dp, ed);
  endtask

  task automatic scan_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_cur(tag);
    end
  endtask

  task automatic do_update(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [3:0] dpv);
    A = a; B = b; C = c; D = d; dp_in = dpv;
    update = 1'b1;
    tick();
    update = 1'b0;
    sh[0] = a; sh[1] = b; sh[2] = c; sh[3] = d;
    sh_dp = dpv;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) sh[i] = 4'hF;
    sh_dp = 4'h0;
    k = 0;
  endtask

  initial begin
    reset_model();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hold_an", an, 4'hF);
    check_eq("rst_hold_seg", seg, 7'h7F);
    check_eq("rst_hold_dp", dp, 1'b1);

    rst = 1'b1;
    k = 0;
    tick();
    check_eq("rel_first_an", an, 4'hE);
    check_cur("rel");
    scan_check("blankcode", 15);

    do_update(4'd4, 4'd3, 4'd2, 4'd1, 4'b0100);
    scan_check("scan", 16);

    do_update(4'd2, 4'd4, 4'd0, 4'd0, 4'b0000);
    scan_check("lz", 16);

    // Update coinciding with the terminal count
    for (int i = 0; i < 8 && (k % 4) != 3; i++) tick();
    check_eq("tc_align", k % 4, 3);
    A = 4'd9; B = 4'd8; C = 4'd7; D = 4'd6; dp_in = 4'b1111;
    update = 1'b1;
    tick();
    update = 1'b0;
    check_cur("tc_old");
    sh[0] = 4'd9; sh[1] = 4'd8; sh[2] = 4'd7; sh[3] = 4'd6;
    sh_dp = 4'b1111;
    tick();
    check_cur("tc_new");
    scan_check("tc_run", 6);

    blank = 1'b1;
    scan_check("blank", 10);
    blank = 1'b0;
    scan_check("resume", 8);

    // Reset in the middle of digit 2
    for (int i = 0; i < 32 && !((((k - 1) / 4) % 4) == 2 && (k % 4) == 2); i++) tick();
    check_eq("mid2_align", ((k - 1) / 4) % 4, 2);
    rst = 1'b0;
    #1;
    check_eq("rst_now_an", an, 4'hF);
    check_eq("rst_now_seg", seg, 7'h7F);
    check_eq("rst_now_dp", dp, 1'b1);
    @(posedge clk);
    #1;
    check_eq("rst_held_an", an, 4'hF);
    rst = 1'b1;
    reset_model();
    tick();
    check_eq("restart_an", an, 4'hE);
    check_cur("restart");
    scan_check("restart_run", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
